// File: rtl/pipe_stage_pkg.sv
// Shared types and payload layout for pipe_stage_register.
// Payload is packed {ctrls, aluout, writedata, writereg}, with writereg in the LSBs.
package pipe_stage_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } state_t;

  localparam int OFF_WRITEREG = 0;

  function automatic int payload_w(input int ctrl_w, input int data_w, input int reg_w);
    return ctrl_w + 2 * data_w + reg_w;
  endfunction

  function automatic int off_writedata(input int reg_w);
    return reg_w;
  endfunction

  function automatic int off_aluout(input int data_w, input int reg_w);
    return reg_w + data_w;
  endfunction

  function automatic int off_ctrls(input int data_w, input int reg_w);
    return reg_w + 2 * data_w;
  endfunction

endpackage

// File: rtl/pipe_stage_if.sv
// Upstream (_e) and downstream (_m) handshake bundle of one pipeline stage register.
// The master side is the surrounding pipeline; the slave side is the stage itself.
interface pipe_stage_if #(
  parameter int CTRL_W = 3,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic              valid_e;
  logic              ready_e;
  logic [CTRL_W-1:0] ctrls_e;
  logic [DATA_W-1:0] aluout_e;
  logic [DATA_W-1:0] writedata_e;
  logic [REG_W-1:0]  writereg_e;
  logic              valid_m;
  logic              ready_m;
  logic [CTRL_W-1:0] ctrls_m;
  logic [DATA_W-1:0] aluout_m;
  logic [DATA_W-1:0] write_data_m;
  logic [REG_W-1:0]  writereg_m;

  modport master (
    output valid_e, ctrls_e, aluout_e, writedata_e, writereg_e, ready_m,
    input  ready_e, valid_m, ctrls_m, aluout_m, write_data_m, writereg_m
  );

  modport slave (
    input  valid_e, ctrls_e, aluout_e, writedata_e, writereg_e, ready_m,
    output ready_e, valid_m, ctrls_m, aluout_m, write_data_m, writereg_m
  );
endinterface

// File: rtl/stage_payload_reg.sv
// Payload holding register with load enable; clears to zero on async reset.
module stage_payload_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_q <= '0;
    else if (i_load) r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

// File: rtl/pipe_stage_register.sv
// Valid/ready pipeline stage register with optional skid entry, flush and stall counter.
// state | meaning
// EMPTY | nothing held, valid_m=0
// BUSY  | output register holds a beat, skid empty
// FULL  | output and skid both hold a beat, ready_e=0
module pipe_stage_register #(
  parameter int CTRL_W      = 3,
  parameter int DATA_W      = 32,
  parameter int REG_W       = 5,
  parameter int SKID        = 1,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  pipe_stage_if.slave            bus,
  output logic [STALL_CNT_W-1:0] stall_cnt
);
  import pipe_stage_pkg::*;

  localparam int PAYLOAD_W = payload_w(CTRL_W, DATA_W, REG_W);
  localparam int OFF_WDATA = off_writedata(REG_W);
  localparam int OFF_ALU   = off_aluout(DATA_W, REG_W);
  localparam int OFF_CTRL  = off_ctrls(DATA_W, REG_W);
  localparam logic [STALL_CNT_W-1:0] STALL_ONE = 1;

  state_t                 r_state, w_next;
  logic                   w_in_fire, w_out_fire, w_valid_m, w_ready_e, w_load_out;
  logic [PAYLOAD_W-1:0]   w_in_payload, w_out_d, w_out_q;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  assign w_valid_m    = (r_state != EMPTY);
  assign w_in_fire    = bus.valid_e & w_ready_e;
  assign w_out_fire   = w_valid_m & bus.ready_m;
  assign w_in_payload = {bus.ctrls_e, bus.aluout_e, bus.writedata_e, bus.writereg_e};

  always_comb begin
    w_next     = r_state;
    w_load_out = 1'b0;
    if (flush) begin
      w_next = EMPTY;
    end else begin
      case (r_state)
        EMPTY: if (w_in_fire) begin
          w_next     = BUSY;
          w_load_out = 1'b1;
        end
        BUSY: begin
          if (w_in_fire && w_out_fire) begin
            w_load_out = 1'b1;
          end else if (w_in_fire) begin
            w_next = FULL;
          end else if (w_out_fire) begin
            w_next = EMPTY;
          end
        end
        FULL: if (w_out_fire) begin
          w_next     = BUSY;
          w_load_out = 1'b1;
        end
        default: w_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= EMPTY;
    else       r_state <= w_next;
  end

  stage_payload_reg #(.W(PAYLOAD_W)) u_out (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_load_out),
    .i_d    (w_out_d),
    .o_q    (w_out_q)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic                 w_load_skid;
      logic [PAYLOAD_W-1:0] w_skid_q;
      logic                 r_ready_e;

      assign w_load_skid = ~flush & (r_state == BUSY) & w_in_fire & ~w_out_fire;

      stage_payload_reg #(.W(PAYLOAD_W)) u_skid (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_load_skid),
        .i_d    (w_in_payload),
        .o_q    (w_skid_q)
      );

      // Draining FULL promotes the skid entry; every other load takes the input beat.
      assign w_out_d = (r_state == FULL) ? w_skid_q : w_in_payload;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) r_ready_e <= 1'b1;
        else       r_ready_e <= (w_next != FULL);
      end
      assign w_ready_e = r_ready_e;
    end else begin : g_noskid
      assign w_out_d   = w_in_payload;
      assign w_ready_e = ~w_valid_m | bus.ready_m;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_valid_m && !bus.ready_m && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + STALL_ONE;
    end
  end

  assign bus.ready_e      = w_ready_e;
  assign bus.valid_m      = w_valid_m;
  assign bus.ctrls_m      = w_valid_m ? w_out_q[OFF_CTRL +: CTRL_W] : '0;
  assign bus.aluout_m     = w_out_q[OFF_ALU +: DATA_W];
  assign bus.write_data_m = w_out_q[OFF_WDATA +: DATA_W];
  assign bus.writereg_m   = w_out_q[OFF_WRITEREG +: REG_W];
  assign stall_cnt        = r_stall_cnt;
endmodule

// File: tb/tb_pipe_stage_register.sv
// Bench for pipe_stage_register: SKID=1 (16-bit and 4-bit stall counter) and SKID=0 builds,
// checked against a queue model of the beats held inside the stage.
module tb_pipe_stage_register;

  typedef struct packed {
    logic [2:0]  c;
    logic [31:0] a;
    logic [31:0] w;
    logic [4:0]  r;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_a, rst_z, flush_a, flush_s, flush_z;
  logic [15:0] stall_a, stall_z;
  logic [3:0]  stall_s;

  pipe_stage_if bus_a ();
  pipe_stage_if bus_s ();
  pipe_stage_if bus_z ();

  pipe_stage_register #(.CTRL_W(3), .DATA_W(32), .REG_W(5), .SKID(1), .STALL_CNT_W(16)) dut_a (
    .clk(clk), .reset(rst_a), .flush(flush_a), .bus(bus_a), .stall_cnt(stall_a));
  pipe_stage_register #(.CTRL_W(3), .DATA_W(32), .REG_W(5), .SKID(1), .STALL_CNT_W(4)) dut_s (
    .clk(clk), .reset(rst_a), .flush(flush_s), .bus(bus_s), .stall_cnt(stall_s));
  pipe_stage_register #(.CTRL_W(3), .DATA_W(32), .REG_W(5), .SKID(0), .STALL_CNT_W(16)) dut_z (
    .clk(clk), .reset(rst_z), .flush(flush_z), .bus(bus_z), .stall_cnt(stall_z));

  always #5 clk = ~clk;

  int    n_pass = 0;
  int    n_total = 0;
  beat_t mq_a[$];
  beat_t mq_z[$];
  int    m_stall_a = 0;

  // Reference model step for the skid build: the stage is a 2-deep FIFO whose
  // ready reflects occupancy after the previous edge.
  task automatic cycle_a(output bit acc);
    bit    infire, outfire, fl;
    beat_t b;
    infire  = (bus_a.valid_e === 1'b1) && (mq_a.size() < 2);
    outfire = (mq_a.size() > 0) && (bus_a.ready_m === 1'b1);
    fl      = (flush_a === 1'b1);
    b       = {bus_a.ctrls_e, bus_a.aluout_e, bus_a.writedata_e, bus_a.writereg_e};
    if (mq_a.size() > 0 && bus_a.ready_m === 1'b0 && m_stall_a < 65535) m_stall_a++;
    @(posedge clk);
    if (fl) mq_a.delete();
    else begin
      if (outfire) void'(mq_a.pop_front());
      if (infire) mq_a.push_back(b);
    end
    acc = infire && !fl;
    #1;
  endtask

  // Reference model step for the no-skid build: 1-deep, ready = empty or draining.
  task automatic cycle_z(output bit acc);
    bit    infire, outfire;
    beat_t b;
    infire  = (bus_z.valid_e === 1'b1) && (mq_z.size() == 0 || bus_z.ready_m === 1'b1);
    outfire = (mq_z.size() > 0) && (bus_z.ready_m === 1'b1);
    b       = {bus_z.ctrls_e, bus_z.aluout_e, bus_z.writedata_e, bus_z.writereg_e};
    @(posedge clk);
    if (outfire) void'(mq_z.pop_front());
    if (infire) mq_z.push_back(b);
    acc = infire;
    #1;
  endtask

  task automatic test_reset();
    beat_t obs;
    rst_a = 1'b1; rst_z = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    obs = {bus_a.ctrls_m, bus_a.aluout_m, bus_a.write_data_m, bus_a.writereg_m};
    n_total++; if (bus_a.valid_m !== 1'b0) $display("FAIL reset_valid_m got %b want 0", bus_a.valid_m); else n_pass++;
    n_total++; if (obs !== '0) $display("FAIL reset_payload got %h want 0", obs); else n_pass++;
    n_total++; if (bus_a.ready_e !== 1'b1) $display("FAIL reset_ready_e got %b want 1", bus_a.ready_e); else n_pass++;
    n_total++; if (stall_a !== 16'd0) $display("FAIL reset_stall got %0d want 0", stall_a); else n_pass++;
    n_total++; if (bus_z.ready_e !== 1'b1) $display("FAIL reset_ready_e_noskid got %b want 1", bus_z.ready_e); else n_pass++;
    n_total++; if (bus_z.valid_m !== 1'b0) $display("FAIL reset_valid_m_noskid got %b want 0", bus_z.valid_m); else n_pass++;
    rst_a = 1'b0; rst_z = 1'b0;
    mq_a.delete(); mq_z.delete(); m_stall_a = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_beat();
    bit    acc;
    beat_t obs, exp_b;
    exp_b = {3'b101, 32'h0000_1234, 32'hDEAD_BEEF, 5'd7};
    bus_a.valid_e = 1'b1; bus_a.ctrls_e = 3'b101; bus_a.aluout_e = 32'h0000_1234;
    bus_a.writedata_e = 32'hDEAD_BEEF; bus_a.writereg_e = 5'd7; bus_a.ready_m = 1'b1;
    cycle_a(acc);
    bus_a.valid_e = 1'b0;
    obs = {bus_a.ctrls_m, bus_a.aluout_m, bus_a.write_data_m, bus_a.writereg_m};
    n_total++; if (bus_a.valid_m !== 1'b1) $display("FAIL single_valid got %b want 1", bus_a.valid_m); else n_pass++;
    n_total++; if (obs !== exp_b) $display("FAIL single_payload got %h want %h", obs, exp_b); else n_pass++;
    cycle_a(acc);
    n_total++; if (bus_a.valid_m !== 1'b0) $display("FAIL single_drain_valid got %b want 0", bus_a.valid_m); else n_pass++;
    n_total++; if (bus_a.ctrls_m !== 3'b000) $display("FAIL single_bubble_ctrls got %b want 000", bus_a.ctrls_m); else n_pass++;
  endtask

  task automatic test_backpressure();
    bit acc;
    int got[$];
    bus_a.ready_m = 1'b0; bus_a.valid_e = 1'b1; bus_a.ctrls_e = 3'b001;
    for (int i = 1; i <= 3; i++) begin
      bus_a.aluout_e = i;
      cycle_a(acc);
    end
    n_total++; if (bus_a.ready_e !== 1'b0) $display("FAIL bp_ready_e_full got %b want 0", bus_a.ready_e); else n_pass++;
    n_total++; if (bus_a.valid_m !== 1'b1 || bus_a.aluout_m !== 32'd1)
      $display("FAIL bp_head got valid=%b alu=%0d want valid=1 alu=1", bus_a.valid_m, bus_a.aluout_m); else n_pass++;
    bus_a.ready_m = 1'b1;
    repeat (6) begin
      if (bus_a.valid_m === 1'b1) got.push_back(int'(bus_a.aluout_m));
      cycle_a(acc);
      if (acc) bus_a.valid_e = 1'b0;
    end
    n_total++; if (got.size() != 3) $display("FAIL bp_count got %0d want 3", got.size()); else n_pass++;
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      n_total++; if (got[i] != i + 1) $display("FAIL bp_order[%0d] got %0d want %0d", i, got[i], i + 1); else n_pass++;
    end
    n_total++; if (stall_a !== 16'd2) $display("FAIL bp_stall got %0d want 2", stall_a); else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit acc;
    bus_a.ready_m = 1'b1; bus_a.valid_e = 1'b1;
    for (int i = 0; i < 100; i++) begin
      bus_a.aluout_e = i;
      n_total++; if (bus_a.ready_e !== 1'b1) $display("FAIL b2b_ready_e[%0d] got %b want 1", i, bus_a.ready_e); else n_pass++;
      cycle_a(acc);
      n_total++; if (bus_a.valid_m !== 1'b1 || bus_a.aluout_m !== 32'(i))
        $display("FAIL b2b_out[%0d] got valid=%b alu=%0d want valid=1 alu=%0d", i, bus_a.valid_m, bus_a.aluout_m, i); else n_pass++;
    end
    bus_a.valid_e = 1'b0;
    cycle_a(acc);
  endtask

  task automatic test_flush_full();
    bit acc;
    bus_a.ready_m = 1'b0; bus_a.valid_e = 1'b1; bus_a.ctrls_e = 3'b111;
    bus_a.aluout_e = 32'd20; cycle_a(acc);
    bus_a.aluout_e = 32'd21; cycle_a(acc);
    flush_a = 1'b1; bus_a.aluout_e = 32'd9;
    cycle_a(acc);
    flush_a = 1'b0; bus_a.valid_e = 1'b0;
    n_total++; if (bus_a.valid_m !== 1'b0) $display("FAIL flush_valid got %b want 0", bus_a.valid_m); else n_pass++;
    n_total++; if (bus_a.ctrls_m !== 3'b000) $display("FAIL flush_ctrls got %b want 000", bus_a.ctrls_m); else n_pass++;
    n_total++; if (bus_a.ready_e !== 1'b1) $display("FAIL flush_ready_e got %b want 1", bus_a.ready_e); else n_pass++;
    n_total++; if (stall_a !== 16'd4) $display("FAIL flush_stall got %0d want 4", stall_a); else n_pass++;
    n_total++; if (bus_a.aluout_m !== 32'd20) $display("FAIL flush_payload_kept got %0d want 20", bus_a.aluout_m); else n_pass++;
    bus_a.ready_m = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle_a(acc);
      n_total++; if (bus_a.valid_m !== 1'b0) $display("FAIL flush_no_beat[%0d] got valid=%b want 0", i, bus_a.valid_m); else n_pass++;
    end
  endtask

  task automatic test_random_a();
    bit    acc = 1'b1;
    beat_t obs;
    for (int i = 0; i < 400; i++) begin
      if (!(bus_a.valid_e === 1'b1 && !acc)) begin
        bus_a.valid_e     = ($urandom_range(0, 3) != 0);
        bus_a.ctrls_e     = 3'($urandom);
        bus_a.aluout_e    = $urandom;
        bus_a.writedata_e = $urandom;
        bus_a.writereg_e  = 5'($urandom);
      end
      bus_a.ready_m = ($urandom_range(0, 2) != 0);
      flush_a       = ($urandom_range(0, 15) == 0);
      cycle_a(acc);
      obs = {bus_a.ctrls_m, bus_a.aluout_m, bus_a.write_data_m, bus_a.writereg_m};
      n_total++; if (bus_a.valid_m !== (mq_a.size() > 0))
        $display("FAIL rnd_valid[%0d] got %b want %b", i, bus_a.valid_m, mq_a.size() > 0); else n_pass++;
      if (mq_a.size() > 0) begin
        n_total++; if (obs !== mq_a[0]) $display("FAIL rnd_payload[%0d] got %h want %h", i, obs, mq_a[0]); else n_pass++;
      end else begin
        n_total++; if (bus_a.ctrls_m !== 3'b000) $display("FAIL rnd_bubble_ctrls[%0d] got %b want 000", i, bus_a.ctrls_m); else n_pass++;
      end
      n_total++; if (bus_a.ready_e !== (mq_a.size() < 2))
        $display("FAIL rnd_ready_e[%0d] got %b want %b", i, bus_a.ready_e, mq_a.size() < 2); else n_pass++;
      n_total++; if (stall_a !== 16'(m_stall_a)) $display("FAIL rnd_stall[%0d] got %0d want %0d", i, stall_a, m_stall_a); else n_pass++;
    end
    flush_a = 1'b0; bus_a.valid_e = 1'b0; bus_a.ready_m = 1'b1;
    repeat (3) cycle_a(acc);
  endtask

  task automatic test_saturation();
    int exp_cnt;
    bus_s.valid_e = 1'b1; bus_s.aluout_e = 32'h55; bus_s.ready_m = 1'b0;
    @(posedge clk); #1;
    bus_s.valid_e = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      exp_cnt = (k > 15) ? 15 : k;
      n_total++; if (stall_s !== 4'(exp_cnt)) $display("FAIL sat_stall[%0d] got %0d want %0d", k, stall_s, exp_cnt); else n_pass++;
    end
    n_total++; if (bus_s.valid_m !== 1'b1 || bus_s.aluout_m !== 32'h55)
      $display("FAIL sat_held got valid=%b alu=%h want valid=1 alu=55", bus_s.valid_m, bus_s.aluout_m); else n_pass++;
    bus_s.ready_m = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_skid0();
    bit acc;
    int v = 100;
    bit exp_rdy;
    bus_z.valid_e = 1'b1; bus_z.ctrls_e = 3'b010; bus_z.writedata_e = 32'hA5A5_0000; bus_z.writereg_e = 5'd3;
    for (int i = 0; i < 30; i++) begin
      bus_z.ready_m  = (i % 3 != 1);
      bus_z.aluout_e = v;
      #1;
      exp_rdy = (mq_z.size() == 0) || bus_z.ready_m;
      n_total++; if (bus_z.ready_e !== exp_rdy) $display("FAIL z_ready_e[%0d] got %b want %b", i, bus_z.ready_e, exp_rdy); else n_pass++;
      cycle_z(acc);
      if (acc) v++;
      n_total++; if (bus_z.valid_m !== (mq_z.size() > 0))
        $display("FAIL z_valid[%0d] got %b want %b", i, bus_z.valid_m, mq_z.size() > 0); else n_pass++;
      if (mq_z.size() > 0) begin
        n_total++; if (bus_z.aluout_m !== mq_z[0].a) $display("FAIL z_order[%0d] got %0d want %0d", i, bus_z.aluout_m, mq_z[0].a); else n_pass++;
      end
    end
    bus_z.ready_m = 1'b0; bus_z.aluout_e = v;
    cycle_z(acc);
    bus_z.valid_e = 1'b0;
    n_total++; if (bus_z.valid_m !== 1'b1) $display("FAIL z_pre_reset_valid got %b want 1", bus_z.valid_m); else n_pass++;
    #1 rst_z = 1'b1;
    #1;
    n_total++; if (bus_z.valid_m !== 1'b0 || bus_z.ctrls_m !== 3'b000 || bus_z.aluout_m !== 32'd0)
      $display("FAIL z_async_reset got valid=%b ctrls=%b alu=%0d want 0/0/0", bus_z.valid_m, bus_z.ctrls_m, bus_z.aluout_m); else n_pass++;
    rst_z = 1'b0;
    mq_z.delete();
    bus_z.valid_e = 1'b1; bus_z.aluout_e = 32'd77; bus_z.ready_m = 1'b1;
    cycle_z(acc);
    bus_z.valid_e = 1'b0;
    n_total++; if (bus_z.valid_m !== 1'b1 || bus_z.aluout_m !== 32'd77)
      $display("FAIL z_after_reset got valid=%b alu=%0d want valid=1 alu=77", bus_z.valid_m, bus_z.aluout_m); else n_pass++;
    cycle_z(acc);
  endtask

  initial begin
    flush_a = 1'b0; flush_s = 1'b0; flush_z = 1'b0;
    rst_a = 1'b1; rst_z = 1'b1;
    bus_a.valid_e = 1'b0; bus_a.ctrls_e = '0; bus_a.aluout_e = '0; bus_a.writedata_e = '0; bus_a.writereg_e = '0; bus_a.ready_m = 1'b1;
    bus_s.valid_e = 1'b0; bus_s.ctrls_e = '0; bus_s.aluout_e = '0; bus_s.writedata_e = '0; bus_s.writereg_e = '0; bus_s.ready_m = 1'b1;
    bus_z.valid_e = 1'b0; bus_z.ctrls_e = '0; bus_z.aluout_e = '0; bus_z.writedata_e = '0; bus_z.writereg_e = '0; bus_z.ready_m = 1'b1;
    test_reset();
    test_single_beat();
    test_backpressure();
    test_back_to_back();
    test_flush_full();
    test_random_a();
    test_saturation();
    test_skid0();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
